// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one word read at a time over
// req/gnt/rvalid, and holds the returned word in a single IF/ID entry.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        misalign_err,
    output logic [1:0]  dbg_state
);

    // Handshakes: a request transfers on a cycle with imem_req && imem_gnt;
    // its data returns on a later cycle with imem_rvalid. The IF/ID entry
    // transfers to decode on a cycle with id_valid && id_ready.
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        slot_free;

    assign slot_free   = !id_valid || id_ready;
    assign imem_req    = (state == S_FETCH) && slot_free && !redirect_valid && !rst;
    assign imem_addr   = {pc[31:2], 2'b00};
    assign id_pc_plus4 = id_pc + 32'd4;
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_FETCH;
            pc           <= RESET_PC;
            req_pc       <= 32'h0;
            id_valid     <= 1'b0;
            id_instr     <= NOP_INSTR;
            id_pc        <= 32'h0;
            misalign_err <= 1'b0;
        end else if (redirect_valid) begin
            // Flush beats both a same-cycle capture and a decode handshake.
            pc           <= {redirect_pc[31:2], 2'b00};
            misalign_err <= |redirect_pc[1:0];
            id_valid     <= 1'b0;
            id_instr     <= NOP_INSTR;
            case (state)
                S_FETCH:   state <= S_FETCH;
                S_WAIT,
                S_DISCARD: state <= imem_rvalid ? S_FETCH : S_DISCARD;
                default:   state <= S_FETCH;
            endcase
        end else begin
            misalign_err <= 1'b0;
            if (id_valid && id_ready) begin
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
            end
            case (state)
                S_FETCH: begin
                    if (imem_req && imem_gnt) begin
                        req_pc <= imem_addr;
                        pc     <= imem_addr + 32'd4;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        id_valid <= 1'b1;
                        id_instr <= imem_rdata;
                        id_pc    <= req_pc;
                        state    <= S_FETCH;
                    end
                end
                S_DISCARD: begin
                    // Response of a flushed request: swallow it, never expose it.
                    if (imem_rvalid) state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-programmable memory responder,
// expected-queue scoreboard for granted addresses and consumed IF/ID entries.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        misalign_err;
    logic [1:0]  dbg_state;

    fetch_stage dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
        .misalign_err(misalign_err), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_id_q[$];   // {pc, instr}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    // Grants while budget > 0; data returns lat cycles after the grant and is
    // 32'h00500093 + address.
    int          budget = 0;
    int          lat = 1;
    bit          pending = 0;
    int          lat_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    bit          g_now;
    logic [31:0] a_now;

    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            imem_rvalid = pending && (lat_cnt == 0);
            imem_rdata  = imem_rvalid ? 32'h0050_0093 + pend_addr : 32'h0;
            imem_gnt    = imem_req && (budget > 0);
            g_now       = imem_gnt;
            a_now       = imem_addr;
            @(posedge clk);
            if (imem_rvalid) pending = 0;
            else if (pending) lat_cnt--;
            if (g_now) begin
                pending   = 1;
                pend_addr = a_now;
                lat_cnt   = lat - 1;
                budget--;
            end
            #1;
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [31:0] ea;
        logic [63:0] ee;
        forever begin
            @(negedge clk);
            #1;
            if (rst !== 1'b1 && imem_req && imem_gnt) begin
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_grant_addr", imem_addr, 32'hxxxx_xxxx);
                end else begin
                    ea = exp_addr_q.pop_front();
                    chk("grant_addr", imem_addr, ea);
                end
            end
            if (rst !== 1'b1 && !redirect_valid && id_valid && id_ready) begin
                if (exp_id_q.size() == 0) begin
                    chk("unexpected_id_pc", id_pc, 32'hxxxx_xxxx);
                end else begin
                    ee = exp_id_q.pop_front();
                    chk("id_instr", id_instr, ee[31:0]);
                    chk("id_pc", id_pc, ee[63:32]);
                    chk("id_pc_plus4", id_pc_plus4, ee[63:32] + 32'd4);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] addr, input logic [31:0] instr);
        exp_addr_q.push_back(addr);
        exp_id_q.push_back({addr, instr});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            step();
            if (budget == 0 && !pending && !id_valid && dbg_state == 2'd0) return;
        end
        chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_pending();
        for (int i = 0; i < 20; i++) begin
            step();
            if (pending) return;
        end
        chk("wait_pending_timeout", 32'd1, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst            = 1'b1;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step();
        step();
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_id_instr", id_instr, NOP);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_pc_plus4", id_pc_plus4, 32'h4);
        chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst_state", {30'b0, dbg_state}, 32'd0);

        // First fetch: gnt immediately, rvalid next cycle; decode stalled.
        expect_fetch(32'h0, 32'h0050_0093);
        budget = 1;
        rst    = 1'b0;
        #1;
        chk("c0_req", {31'b0, imem_req}, 32'd1);
        chk("c0_addr", imem_addr, 32'h0);
        step();
        chk("c1_state_wait", {30'b0, dbg_state}, 32'd1);
        step();
        chk("c2_id_valid", {31'b0, id_valid}, 32'd1);
        chk("c2_id_instr", id_instr, 32'h0050_0093);
        chk("c2_id_pc", id_pc, 32'h0);
        chk("c2_id_pc_plus4", id_pc_plus4, 32'h4);
        chk("c2_next_addr", imem_addr, 32'h4);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            chk("bp_req", {31'b0, imem_req}, 32'd0);
            chk("bp_instr", id_instr, 32'h0050_0093);
            chk("bp_pc", id_pc, 32'h0);
        end
        step();
        id_ready = 1'b1;
        #1;
        chk("bp_release_req", {31'b0, imem_req}, 32'd1);
        chk("bp_release_addr", imem_addr, 32'h4);
        expect_fetch(32'h4, 32'h0050_0097);
        expect_fetch(32'h8, 32'h0050_009B);
        budget = 2;
        wait_idle();

        // Redirect while waiting on a slow response.
        exp_addr_q.push_back(32'hC);
        lat    = 3;
        budget = 1;
        wait_pending();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("rd_state_discard", {30'b0, dbg_state}, 32'd2);
        chk("rd_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rd_addr", imem_addr, 32'h100);
        chk("rd_req_discard", {31'b0, imem_req}, 32'd0);
        step();
        chk("rd_still_discard", {30'b0, dbg_state}, 32'd2);
        step();
        chk("rd_back_fetch", {30'b0, dbg_state}, 32'd0);
        chk("rd_req", {31'b0, imem_req}, 32'd1);
        chk("rd_req_addr", imem_addr, 32'h100);
        expect_fetch(32'h100, 32'h0050_0193);
        lat    = 1;
        budget = 1;
        wait_idle();

        // Redirect on the same cycle as rvalid with decode ready.
        exp_addr_q.push_back(32'h104);
        lat    = 2;
        budget = 1;
        wait_pending();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("rv_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rv_id_instr", id_instr, NOP);
        chk("rv_state", {30'b0, dbg_state}, 32'd0);
        chk("rv_req", {31'b0, imem_req}, 32'd1);
        chk("rv_addr", imem_addr, 32'h40);
        expect_fetch(32'h40, 32'h0050_00D3);
        lat    = 1;
        budget = 1;
        wait_idle();

        // Misaligned redirect target.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0202;
        #1;
        chk("mis_req_suppressed", {31'b0, imem_req}, 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("mis_pulse", {31'b0, misalign_err}, 32'd1);
        chk("mis_addr", imem_addr, 32'h200);
        step();
        chk("mis_pulse_end", {31'b0, misalign_err}, 32'd0);
        expect_fetch(32'h200, 32'h0050_0293);
        budget = 1;
        wait_idle();

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_misalign", {31'b0, misalign_err}, 32'd0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        expect_fetch(32'hFFFF_FFFC, 32'h0050_008F);
        budget = 1;
        wait_idle();
        chk("wrap_next_addr", imem_addr, 32'h0);

        // Reset while a response is outstanding.
        exp_addr_q.push_back(32'h0);
        lat    = 3;
        budget = 1;
        wait_pending();
        rst = 1'b1;
        #1;
        chk("mr_req_in_rst", {31'b0, imem_req}, 32'd0);
        step();
        chk("mr_id_valid", {31'b0, id_valid}, 32'd0);
        chk("mr_id_instr", id_instr, NOP);
        chk("mr_id_pc", id_pc, 32'h0);
        chk("mr_state", {30'b0, dbg_state}, 32'd0);
        rst = 1'b0;
        #1;
        chk("mr_req", {31'b0, imem_req}, 32'd1);
        chk("mr_addr", imem_addr, 32'h0);
        step();
        step();
        chk("mr_late_rvalid_ignored", {31'b0, id_valid}, 32'd0);
        chk("mr_state_fetch", {30'b0, dbg_state}, 32'd0);
        expect_fetch(32'h0, 32'h0050_0093);
        lat    = 1;
        budget = 1;
        wait_idle();

        // ---------------- final report ----------------
        repeat (3) step();
        chk("addr_q_drained", exp_addr_q.size(), 32'd0);
        chk("id_q_drained", exp_id_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
